// File: rtl/fifo_serial_tx.sv
// Pops 12-bit words from the FIFO and sends each one as a serial frame: start bit, LSB-first data, stop bit.
// Defining FIFO_SERIAL_TX_PARITY_EN adds an even-parity bit between the last data bit and stop.
module fifo_serial_tx #(
    parameter int BITS         = 12,
    parameter int CLKS_PER_BIT = 4,
    parameter int DIV_WIDTH    = 8,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_ready,
    input  logic [BITS-1:0]      fifo_data,
    output logic                 fifo_read,
    input  logic                 tx_enable,
    output logic                 ser_out,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frame_count
);

    localparam int IDX_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BITS - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
`ifdef FIFO_SERIAL_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state, state_next;
    logic [DIV_WIDTH-1:0]  div;
    logic [IDX_W-1:0]      bit_idx;
    logic [BITS-1:0]       shift;
`ifdef FIFO_SERIAL_TX_PARITY_EN
    logic                  parity_bit;
`endif

    logic div_last;
    logic bit_last;
    logic start_ok;

    assign div_last  = (div == DIV_LAST);
    assign bit_last  = (bit_idx == LAST_IDX);
    assign start_ok  = tx_enable && fifo_ready;
    assign fifo_read = (state == LOAD);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            frame_count <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: div <= '0;
                LOAD: begin
                    // Word and FIFO pop share this edge; later FIFO changes cannot reach the frame.
                    shift   <= fifo_data;
                    div     <= '0;
                    bit_idx <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
                    parity_bit <= ^fifo_data;
`endif
                end
                default: begin
                    div <= div_last ? '0 : div + 1'b1;
                    if (state == DATA && div_last) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                    if (state == STOP && div_last) begin
                        frame_count <= frame_count + 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        ser_out    = 1'b1;
        case (state)
            IDLE: begin
                if (start_ok) state_next = LOAD;
            end
            LOAD: state_next = START;
            START: begin
                ser_out = 1'b0;
                if (div_last) state_next = DATA;
            end
            DATA: begin
                ser_out = shift[0];
                if (div_last && bit_last) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef FIFO_SERIAL_TX_PARITY_EN
            PARITY: begin
                ser_out = parity_bit;
                if (div_last) state_next = STOP;
            end
`endif
            STOP: begin
                if (div_last) state_next = start_ok ? LOAD : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
